remote_comm: RTL and testbench
==============================

Name: remote_comm

Overview:
- Host/BLE-side counterpart of the robot's UART command link.
- Serializes a 16-bit Knight's Tour command into two 8N1 UART bytes, high byte first.
- Independently receives the robot's 1-byte responses: 0x5A (in progress) and 0xA5 (done).
- Used as the stimulus engine in full-chip benches and as the command source on the remote controller FPGA.

Parameters:
- BAUD_DIV, 2604, clk cycles per UART bit (50MHz / 19200); benches use 16.
- RESP_TIMEOUT, 22'd2_500_000, cycles after cmd_sent with no response byte before resp_tmo asserts.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd  in  16  command word to transmit
- send_cmd  in  1  single-cycle request to send cmd
- cmd_sent  out  1  both bytes fully shifted out; sticky until next accepted send_cmd
- busy  out  1  high from accepted send_cmd until second byte's stop bit completes
- TX  out  1  UART serial out, idles high
- RX  in  1  UART serial in (asynchronous, double-flopped)
- resp  out  8  last received response byte
- resp_rdy  out  1  new resp available; sticky
- clr_resp_rdy  in  1  clears resp_rdy
- resp_tmo  out  1  no response within RESP_TIMEOUT after cmd_sent

Behaviour:
- Reset values:
  - cmd_sent=0, busy=0, TX=1, resp=8'h00, resp_rdy=0, resp_tmo=0.
  - FSM in IDLE, cmd_buf=0.
- Command FSM states: IDLE, HIGH, LOW.
  - IDLE: send_cmd=1 → latch cmd into cmd_buf[15:0]; clear cmd_sent and resp_tmo; clear resp_rdy; busy=1; pulse trmt with cmd_buf[15:8]; go to HIGH.
  - HIGH: on tx_done, pulse trmt with cmd_buf[7:0]; go to LOW.
  - LOW: on tx_done, set cmd_sent=1, busy=0, start timeout counter; go to IDLE.
  - send_cmd while busy is ignored. cmd_buf is not updated and no error is flagged.
  - cmd changes after acceptance have no effect on the bytes sent.
- Transmit framing and latency:
  - Per byte: start bit 0, 8 data bits LSB first, stop bit 1, each bit exactly BAUD_DIV cycles.
  - The first byte's start bit appears on TX 1 cycle after send_cmd is accepted.
  - The two bytes are back-to-back, with no idle gap beyond the 1-cycle trmt handoff.
  - cmd_sent rises 20*BAUD_DIV+2 cycles (±1) after send_cmd.
- Receiver:
  - Always active, independent of the command FSM.
  - Double-flops RX. Detects a falling edge while idle and samples each bit at BAUD_DIV/2.
  - On a valid stop-bit sample: load resp, set resp_rdy, clear the timeout counter.
  - Framing error (stop bit = 0): discard the byte; resp and resp_rdy are unchanged.
  - A byte arriving while resp_rdy=1 overwrites resp; resp_rdy stays 1.
  - clr_resp_rdy and byte completion in the same cycle: set wins.
- Timeout:
  - 22-bit counter runs only while cmd_sent=1, no byte has been received since cmd_sent, and resp_tmo=0.
  - Reaching RESP_TIMEOUT-1 sets resp_tmo. resp_tmo is sticky until the next accepted send_cmd.
  - 0x5A counts as a response and stops the timeout. Later bytes still update resp.
- Reset mid-frame: TX returns high immediately (asynchronous), any partial frame is abandoned, and all state returns to reset values.

Decomposition:
- Package remote_comm_pkg:
  - Enum cmd_state_t {IDLE,HIGH,LOW}.
  - Constants RESP_DONE=8'hA5, RESP_PROG=8'h5A.
  - Command opcode field positions cmd[15:12], for bench use.
- One sub-module, uart_trx:
  - 8N1 transmitter and receiver sharing BAUD_DIV.
  - Ports: trmt, tx_data, tx_done, rx_rdy, rx_data, framing_err.
- remote_comm holds the command FSM, cmd_buf, response latch and timeout counter.

Test Plan:
- BAUD_DIV=16, cmd=16'h2C7F, send_cmd pulse → TX carries bytes 0x2C then 0x7F (LSB first, 10 bits each, 16 cycles/bit); cmd_sent rises at cycle 322±1; busy low at the same cycle.
- During busy, pulse send_cmd with cmd=16'hFFFF → transmitted bytes remain 0x2C, 0x7F; no third byte follows.
- Drive RX with 0x5A then 0xA5 (BAUD_DIV=16 frames) → resp=0x5A with resp_rdy=1; after clr_resp_rdy, resp_rdy=0; then resp=0xA5 with resp_rdy=1.
- RESP_TIMEOUT=100, send cmd, no RX activity → resp_tmo=1 exactly 100 cycles after cmd_sent; next send_cmd clears it.
- RX frame with stop bit = 0 carrying 0x33 → resp unchanged (0x00), resp_rdy=0; the following good frame 0xA5 is accepted.
- Assert rst_n=0 midway through the second byte → TX=1 and busy=0 immediately; after release, a new send_cmd of 16'h1234 transmits cleanly.

Source files
------------

// File: rtl/remote_comm_pkg.sv
// remote_comm_pkg: shared types and constants for the remote command link.
// Holds the command FSM state enum, robot response codes and opcode field.
package remote_comm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } cmd_state_t;

    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_PROG = 8'h5A;

    localparam int CMD_OP_MSB = 15;
    localparam int CMD_OP_LSB = 12;

endpackage

// File: rtl/remote_comm_uart_trx.sv
// uart_trx: 8N1 UART transmitter and receiver sharing one bit period.
// Ports: clk, rst_n, trmt/tx_data -> TX, tx_done; RX -> rx_rdy/rx_data,
// framing_err. tx_done is combinational in the last stop-bit cycle so a
// following trmt in that cycle starts the next frame with no gap.
module uart_trx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       TX,
    input  logic       RX,
    output logic       rx_rdy,
    output logic [7:0] rx_data,
    output logic       framing_err
);

    localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BAUD_MID  = BW'(BAUD_DIV / 2);

    // Transmitter
    logic          r_tx_busy;
    logic [BW-1:0] r_tx_baud;
    logic [3:0]    r_tx_bit;
    logic [7:0]    r_tx_sr;
    logic          r_tx;
    logic          w_tx_tick;
    logic          w_tx_end;

    assign w_tx_tick = r_tx_busy && (r_tx_baud == BAUD_LAST);
    assign w_tx_end  = w_tx_tick && (r_tx_bit == 4'd9);
    assign tx_done   = w_tx_end;
    assign TX        = r_tx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_busy <= 1'b0;
            r_tx_baud <= '0;
            r_tx_bit  <= 4'd0;
            r_tx_sr   <= 8'h00;
            r_tx      <= 1'b1;
        end else if (trmt) begin
            r_tx_busy <= 1'b1;
            r_tx_baud <= '0;
            r_tx_bit  <= 4'd0;
            r_tx_sr   <= tx_data;
            r_tx      <= 1'b0;
        end else if (w_tx_end) begin
            r_tx_busy <= 1'b0;
            r_tx_baud <= '0;
            r_tx      <= 1'b1;
        end else if (w_tx_tick) begin
            // shifting in ones makes the stop bit fall out naturally
            r_tx_baud <= '0;
            r_tx_bit  <= r_tx_bit + 4'd1;
            r_tx      <= r_tx_sr[0];
            r_tx_sr   <= {1'b1, r_tx_sr[7:1]};
        end else if (r_tx_busy) begin
            r_tx_baud <= r_tx_baud + BW'(1);
        end
    end

    // Receiver
    logic          r_rx_ff1;
    logic          r_rx_ff2;
    logic          r_rx_prev;
    logic          r_rx_busy;
    logic [BW-1:0] r_rx_baud;
    logic [3:0]    r_rx_bit;
    logic [7:0]    r_rx_sr;
    logic          r_rx_rdy;
    logic          r_ferr;
    logic          w_rx_fall;

    assign w_rx_fall   = r_rx_prev & ~r_rx_ff2;
    assign rx_rdy      = r_rx_rdy;
    assign rx_data     = r_rx_sr;
    assign framing_err = r_ferr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_ff1  <= 1'b1;
            r_rx_ff2  <= 1'b1;
            r_rx_prev <= 1'b1;
            r_rx_busy <= 1'b0;
            r_rx_baud <= '0;
            r_rx_bit  <= 4'd0;
            r_rx_sr   <= 8'h00;
            r_rx_rdy  <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_rx_ff1  <= RX;
            r_rx_ff2  <= r_rx_ff1;
            r_rx_prev <= r_rx_ff2;
            r_rx_rdy  <= 1'b0;
            r_ferr    <= 1'b0;
            if (!r_rx_busy) begin
                if (w_rx_fall) begin
                    r_rx_busy <= 1'b1;
                    r_rx_baud <= '0;
                    r_rx_bit  <= 4'd0;
                end
            end else begin
                if (r_rx_baud == BAUD_LAST) begin
                    r_rx_baud <= '0;
                    r_rx_bit  <= r_rx_bit + 4'd1;
                end else begin
                    r_rx_baud <= r_rx_baud + BW'(1);
                end
                if (r_rx_baud == BAUD_MID) begin
                    if (r_rx_bit == 4'd0) begin
                        // start bit gone high again: glitch, not a frame
                        if (r_rx_ff2) r_rx_busy <= 1'b0;
                    end else if (r_rx_bit == 4'd9) begin
                        // release mid-stop so a back-to-back start is seen
                        r_rx_busy <= 1'b0;
                        if (r_rx_ff2) r_rx_rdy <= 1'b1;
                        else          r_ferr   <= 1'b1;
                    end else begin
                        r_rx_sr <= {r_rx_ff2, r_rx_sr[7:1]};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/remote_comm.sv
// remote_comm: sends a 16-bit command as two UART bytes (high first) and
// latches the robot's 1-byte responses, with a no-response timeout.
// Ports: cmd/send_cmd in, busy/cmd_sent out, TX/RX serial,
// resp/resp_rdy/clr_resp_rdy response latch, resp_tmo timeout flag.
module remote_comm
    import remote_comm_pkg::*;
#(
    parameter int          BAUD_DIV     = 2604,
    parameter logic [21:0] RESP_TIMEOUT = 22'd2_500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        send_cmd,
    output logic        cmd_sent,
    output logic        busy,
    output logic        TX,
    input  logic        RX,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    input  logic        clr_resp_rdy,
    output logic        resp_tmo
);

    cmd_state_t  r_state;
    cmd_state_t  w_next;
    logic        w_trmt;
    logic [7:0]  w_tx_data;
    logic        w_accept;
    logic        w_done;
    logic        w_tx_done;
    logic        w_rx_rdy;
    logic [7:0]  w_rx_data;
    logic        w_ferr;
    logic        w_rx_ok;

    logic [15:0] r_cmd_buf;
    logic        r_cmd_sent;
    logic        r_busy;
    logic [7:0]  r_resp;
    logic        r_resp_rdy;
    logic        r_tmo;
    logic        r_got;
    logic [21:0] r_tmo_cnt;

    uart_trx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_trx (
        .clk         (clk),
        .rst_n       (rst_n),
        .trmt        (w_trmt),
        .tx_data     (w_tx_data),
        .tx_done     (w_tx_done),
        .TX          (TX),
        .RX          (RX),
        .rx_rdy      (w_rx_rdy),
        .rx_data     (w_rx_data),
        .framing_err (w_ferr)
    );

    assign w_rx_ok = w_rx_rdy & ~w_ferr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // first byte comes straight from cmd so it starts one cycle after accept
    always_comb begin
        w_next    = r_state;
        w_trmt    = 1'b0;
        w_tx_data = r_cmd_buf[15:8];
        w_accept  = 1'b0;
        w_done    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (send_cmd) begin
                    w_accept  = 1'b1;
                    w_trmt    = 1'b1;
                    w_tx_data = cmd[15:8];
                    w_next    = HIGH;
                end
            end
            HIGH: begin
                if (w_tx_done) begin
                    w_trmt    = 1'b1;
                    w_tx_data = r_cmd_buf[7:0];
                    w_next    = LOW;
                end
            end
            LOW: begin
                if (w_tx_done) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_buf  <= 16'h0000;
            r_cmd_sent <= 1'b0;
            r_busy     <= 1'b0;
            r_resp     <= 8'h00;
            r_resp_rdy <= 1'b0;
            r_tmo      <= 1'b0;
            r_got      <= 1'b0;
            r_tmo_cnt  <= 22'd0;
        end else begin
            if (r_cmd_sent && !r_got && !r_tmo) begin
                if (r_tmo_cnt == RESP_TIMEOUT - 22'd1) r_tmo <= 1'b1;
                else r_tmo_cnt <= r_tmo_cnt + 22'd1;
            end
            if (w_accept || clr_resp_rdy) r_resp_rdy <= 1'b0;
            if (w_accept) begin
                r_cmd_buf  <= cmd;
                r_cmd_sent <= 1'b0;
                r_tmo      <= 1'b0;
                r_busy     <= 1'b1;
            end
            if (w_done) begin
                r_cmd_sent <= 1'b1;
                r_busy     <= 1'b0;
                r_tmo_cnt  <= 22'd0;
                r_got      <= 1'b0;
            end
            // a completed byte beats any clear in the same cycle
            if (w_rx_ok) begin
                r_resp     <= w_rx_data;
                r_resp_rdy <= 1'b1;
                r_got      <= 1'b1;
                r_tmo_cnt  <= 22'd0;
            end
        end
    end

    assign cmd_sent = r_cmd_sent;
    assign busy     = r_busy;
    assign resp     = r_resp;
    assign resp_rdy = r_resp_rdy;
    assign resp_tmo = r_tmo;

endmodule

// File: tb/tb_remote_comm.sv
// tb_remote_comm: randomized scoreboard bench for remote_comm.
// Expected TX bytes and responses are queued at stimulus time and popped
// by independent monitors that decode the serial line and resp_rdy.
module tb_remote_comm;
    import remote_comm_pkg::*;

    localparam int          BD = 16;
    localparam logic [21:0] RT = 22'd100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cmd = 16'h0000;
    logic        send_cmd = 1'b0;
    logic        cmd_sent;
    logic        busy;
    logic        TX;
    logic        RX = 1'b1;
    logic [7:0]  resp;
    logic        resp_rdy;
    logic        clr_resp_rdy = 1'b0;
    logic        resp_tmo;

    int checks = 0;
    int errors = 0;
    int tx_seen = 0;
    bit frame_rst = 1'b0;
    logic [7:0] tx_q[$];
    logic [7:0] rsp_q[$];

    remote_comm #(
        .BAUD_DIV     (BD),
        .RESP_TIMEOUT (RT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd          (cmd),
        .send_cmd     (send_cmd),
        .cmd_sent     (cmd_sent),
        .busy         (busy),
        .TX           (TX),
        .RX           (RX),
        .resp         (resp),
        .resp_rdy     (resp_rdy),
        .clr_resp_rdy (clr_resp_rdy),
        .resp_tmo     (resp_tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge rst_n) frame_rst = 1'b1;

    // TX line decoder: mid-bit sampling of each 8N1 frame
    initial begin : tx_mon
        logic [7:0] b;
        logic st;
        logic sp;
        forever begin
            @(negedge clk);
            if (rst_n && TX === 1'b0) begin
                frame_rst = 1'b0;
                repeat (BD / 2) @(negedge clk);
                st = TX;
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge clk);
                    b[i] = TX;
                end
                repeat (BD) @(negedge clk);
                sp = TX;
                if (!frame_rst) begin
                    tx_seen++;
                    if (tx_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_extra: got byte %02h expected none", b);
                    end else begin
                        chk("tx_frame", {22'd0, st, sp, b},
                            {22'd0, 1'b0, 1'b1, tx_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin : rsp_mon
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_rdy && !prev) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_extra: got %02h expected none", resp);
                end else begin
                    chk("resp", {24'd0, resp}, {24'd0, rsp_q.pop_front()});
                end
            end
            prev = resp_rdy;
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rx_frame(input logic [7:0] b, input bit good);
        logic [9:0] f;
        f = {good, b, 1'b0};
        if (good) rsp_q.push_back(b);
        for (int i = 0; i < 10; i++) begin
            RX = f[i];
            step(BD);
        end
        RX = 1'b1;
    endtask

    task automatic clr_pulse();
        clr_resp_rdy = 1'b1;
        step(1);
        clr_resp_rdy = 1'b0;
    endtask

    task automatic send(input logic [15:0] c, input bit inject,
                        output int lat);
        cmd = c;
        send_cmd = 1'b1;
        tx_q.push_back(c[15:8]);
        tx_q.push_back(c[7:0]);
        step(1);
        send_cmd = 1'b0;
        cmd = 16'($urandom);
        chk("busy_on_accept", {31'd0, busy}, 32'd1);
        chk("sent_clr_on_accept", {31'd0, cmd_sent}, 32'd0);
        chk("tmo_clr_on_accept", {31'd0, resp_tmo}, 32'd0);
        lat = 1;
        while (!cmd_sent && lat < 1000) begin
            if (inject && lat == 50) begin
                cmd = 16'hFFFF;
                send_cmd = 1'b1;
            end else begin
                send_cmd = 1'b0;
            end
            step(1);
            lat++;
        end
        send_cmd = 1'b0;
        checks++;
        if (lat < 321 || lat > 323) begin
            errors++;
            $display("FAIL cmd_sent_latency: got %0d expected 322+-1", lat);
        end
        chk("busy_low_at_sent", {31'd0, busy}, 32'd0);
        chk("tx_q_drained", tx_q.size(), 32'd0);
    endtask

    initial begin : main
        int lat;
        int n;
        step(3);
        chk("rst_tx", {31'd0, TX}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cmd_sent", {31'd0, cmd_sent}, 32'd0);
        chk("rst_resp", {24'd0, resp}, 32'd0);
        chk("rst_resp_rdy", {31'd0, resp_rdy}, 32'd0);
        chk("rst_resp_tmo", {31'd0, resp_tmo}, 32'd0);
        rst_n = 1'b1;
        step(5);

        rx_frame(8'h33, 1'b0);
        step(20);
        chk("ferr_resp", {24'd0, resp}, 32'd0);
        chk("ferr_rdy", {31'd0, resp_rdy}, 32'd0);
        rx_frame(RESP_DONE, 1'b1);
        step(5);
        chk("after_ferr_resp", {24'd0, resp}, {24'd0, RESP_DONE});
        chk("after_ferr_rdy", {31'd0, resp_rdy}, 32'd1);

        clr_pulse();
        chk("clr_rdy", {31'd0, resp_rdy}, 32'd0);
        rx_frame(RESP_PROG, 1'b1);
        step(5);
        chk("prog_rdy", {31'd0, resp_rdy}, 32'd1);
        clr_pulse();
        chk("clr_rdy2", {31'd0, resp_rdy}, 32'd0);
        rx_frame(RESP_DONE, 1'b1);
        step(5);
        chk("done_resp", {24'd0, resp}, {24'd0, RESP_DONE});
        clr_pulse();

        tx_seen = 0;
        send(16'h2C7F, 1'b1, lat);
        n = 0;
        while (!resp_tmo && n < 500) begin
            step(1);
            n++;
        end
        chk("tmo_latency", n, 32'd100);
        step(200);
        chk("no_third_byte", tx_seen, 32'd2);

        for (int k = 0; k < 4; k++) begin
            send(16'($urandom), 1'b0, lat);
            step(40 + int'($urandom_range(0, 80)));
        end

        fork
            send(16'($urandom), 1'b0, lat);
            begin
                step(241);
                rx_frame(RESP_PROG, 1'b1);
            end
        join
        step(200);
        chk("prog_stops_tmo", {31'd0, resp_tmo}, 32'd0);
        chk("prog_resp", {24'd0, resp}, {24'd0, RESP_PROG});

        cmd = 16'($urandom);
        send_cmd = 1'b1;
        tx_q.push_back(cmd[15:8]);
        tx_q.push_back(cmd[7:0]);
        step(1);
        send_cmd = 1'b0;
        step(239);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", {31'd0, TX}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_rdy", {31'd0, resp_rdy}, 32'd0);
        chk("midrst_resp", {24'd0, resp}, 32'd0);
        step(2);
        rst_n = 1'b1;
        tx_q.delete();
        step(200);
        send(16'h1234, 1'b0, lat);
        step(50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
